// File: rtl/acc_bus_pkg.sv
// ---------------------------------------------------------------------------
// acc_bus_pkg
// Shared definitions for the router <-> accelerator bus. The router, the
// accelerators and acc_fifo_bridge all take their word width and queue
// depth from here so the two sides can never disagree.
//   ACC_DATA_W : bus word width in bits
//   ACC_DEPTH  : entries per bridge FIFO (power of two, >= 2)
//   fifo_status_t : empty/full pair reported by each bridge queue
// ---------------------------------------------------------------------------
package acc_bus_pkg;

   localparam int ACC_DATA_W = 32;
   localparam int ACC_DEPTH  = 8;

   typedef struct packed {
      logic empty;
      logic full;
   } fifo_status_t;

endpackage : acc_bus_pkg

// File: rtl/acc_fifo_bridge_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO used for both directions of the
// bridge. Push/pop legality is judged on the registered full/empty flags as
// they stand before the edge, so a push while full is refused even when a
// pop happens on the same edge (and vice versa for a pop while empty).
// Ports:
//   clk        : clock, all state changes on the rising edge
//   reset      : asynchronous active-low reset, clears pointers and count
//   push       : write request
//   push_data  : word written at the tail when the push is legal
//   pop        : read request (advances the head when legal)
//   head_data  : word currently at the head (valid while !empty)
//   empty/full : registered status, empty <=> count==0, full <=> count==DEPTH
// ---------------------------------------------------------------------------
module sync_fifo
   import acc_bus_pkg::*;
#(
   parameter int DATA_W = ACC_DATA_W,
   parameter int DEPTH  = ACC_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              empty,
   output logic              full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic [CW-1:0]     count_next_s;
   logic              empty_r;
   logic              full_r;
   logic              push_ok_s;
   logic              pop_ok_s;

   // Legal-operation decode and next occupancy.
   always_comb begin
      push_ok_s    = push & ~full_r;
      pop_ok_s     = pop & ~empty_r;
      count_next_s = count_r;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_next_s = count_r + CW'(1);
         2'b01:   count_next_s = count_r - CW'(1);
         default: count_next_s = count_r;
      endcase
   end

   // Pointers, occupancy and registered status flags.
   // DEPTH is a power of two, so AW-bit pointer increments wrap modulo DEPTH.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_next_s;
         empty_r <= (count_next_s == {CW{1'b0}});
         full_r  <= (count_next_s == CW'(DEPTH));
      end
   end

   // Storage array; contents need no reset because the count gates every read.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head_data = mem_r[rd_ptr_r];
   assign empty     = empty_r;
   assign full      = full_r;

endmodule : sync_fifo

// File: rtl/acc_fifo_bridge.sv
// ---------------------------------------------------------------------------
// acc_fifo_bridge
// Decouples the router from an accelerator with two independent FIFOs:
//   to-FIFO   : router put_req/data_in  -> accelerator acc_rd_* (FWFT)
//   from-FIFO : accelerator acc_wr_*    -> router get_req/data_out
// Ports:
//   clk, reset                 : clock and asynchronous active-low reset
//   put_req, data_in           : router push into the to-FIFO
//   get_req, data_out          : router pop from the from-FIFO; data_out is
//                                registered, visible one cycle after get_req
//   to_empty, to_full          : to-FIFO status
//   from_empty, from_full      : from-FIFO status
//   acc_rd_valid/data/ready    : accelerator consume side of the to-FIFO
//   acc_wr_valid/data/ready    : accelerator produce side of the from-FIFO
//   overflow, underflow        : sticky router-side error flags, cleared
//                                only by reset
// ---------------------------------------------------------------------------
module acc_fifo_bridge
   import acc_bus_pkg::*;
#(
   parameter int DATA_W = ACC_DATA_W,
   parameter int DEPTH  = ACC_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              put_req,
   input  logic [DATA_W-1:0] data_in,
   input  logic              get_req,
   output logic [DATA_W-1:0] data_out,
   output logic              to_empty,
   output logic              to_full,
   output logic              from_empty,
   output logic              from_full,
   output logic              acc_rd_valid,
   output logic [DATA_W-1:0] acc_rd_data,
   input  logic              acc_rd_ready,
   input  logic              acc_wr_valid,
   input  logic [DATA_W-1:0] acc_wr_data,
   output logic              acc_wr_ready,
   output logic              overflow,
   output logic              underflow
);

   fifo_status_t      to_stat_s;
   fifo_status_t      from_stat_s;
   logic [DATA_W-1:0] from_head_s;
   logic [DATA_W-1:0] data_out_r;
   logic              overflow_r;
   logic              underflow_r;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_to_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (put_req),
      .push_data (data_in),
      .pop       (acc_rd_ready),
      .head_data (acc_rd_data),
      .empty     (to_stat_s.empty),
      .full      (to_stat_s.full)
   );

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_from_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (acc_wr_valid),
      .push_data (acc_wr_data),
      .pop       (get_req),
      .head_data (from_head_s),
      .empty     (from_stat_s.empty),
      .full      (from_stat_s.full)
   );

   // Router read register and sticky error flags. The FIFO refuses illegal
   // requests by itself; here we only record that one was attempted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out_r  <= {DATA_W{1'b0}};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (get_req && !from_stat_s.empty) begin
            data_out_r <= from_head_s;
         end
         if (put_req && to_stat_s.full) begin
            overflow_r <= 1'b1;
         end
         if (get_req && from_stat_s.empty) begin
            underflow_r <= 1'b1;
         end
      end
   end

   assign data_out     = data_out_r;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;
   assign to_empty     = to_stat_s.empty;
   assign to_full      = to_stat_s.full;
   assign from_empty   = from_stat_s.empty;
   assign from_full    = from_stat_s.full;
   assign acc_rd_valid = ~to_stat_s.empty;
   assign acc_wr_ready = ~from_stat_s.full;

endmodule : acc_fifo_bridge
